// File: rtl/mux_n_reg.sv
// mux_n_reg: N-way input select feeding a two-entry elastic output stage.
//
// On every accept the block takes one WIDTH-bit slice of in_data, chosen by
// in_sel, and stores it. An index past the last input stores all-zeros.
// Storage is an output register plus one skid register. Both handshake
// outputs come straight from the state register, so there is no
// combinational path from in_valid or out_ready to in_ready or out_valid.
//
// Optional feature: define MUX_N_REG_SELERR_EN to enable the sticky sel_err
// flag. Without it, sel_err is tied to 0 and err_clr is ignored.
//
// Parameters
//   WIDTH   data width of each input and of the output (>= 1)
//   NUM_IN  number of selectable inputs (>= 2)
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    packed inputs; input i is in_data[i*WIDTH +: WIDTH]
//   in_sel     index of the selected input
//   in_valid   upstream offers in_data/in_sel
//   in_ready   block can accept this cycle
//   out_data   selected, registered word
//   out_valid  out_data holds a valid word
//   out_ready  downstream consumes out_data
//   err_clr    clears sel_err
//   sel_err    sticky out-of-range-select flag
module mux_n_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  localparam int SEL_W = ($clog2(NUM_IN) < 1) ? 1 : $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [WIDTH-1:0] sel_word;
  logic             accept, release_w;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != TWO);
  assign out_data  = out_q;

  assign accept    = in_valid & in_ready;
  assign release_w = out_valid & out_ready;

  // Only indices that name a real input match. An out-of-range index falls
  // through to the all-zeros default.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_sel == SEL_W'(i)) sel_word = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          out_d   = sel_word;
        end
      end
      ONE: begin
        if (accept && release_w) begin
          out_d = sel_word;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = sel_word;
        end else if (release_w) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so the only event is a release.
        if (release_w) begin
          state_d = ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

`ifdef MUX_N_REG_SELERR_EN
  logic sel_oor;
  logic err_q, err_d;

  assign sel_oor = (32'(in_sel) >= NUM_IN);

  // If a set and a clear land on the same edge, the set wins.
  always_comb begin
    err_d = err_q;
    if (accept && sel_oor) err_d = 1'b1;
    else if (err_clr)      err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign sel_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign sel_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
module tb_mux_n_reg;
  localparam int WIDTH  = 8;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid, in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid, out_ready;
  logic                    err_clr, sel_err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MUX_N_REG_SELERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Reference model: a FIFO of at most two words. The head is what the
  // output shows, and m_out keeps the last head once the FIFO drains.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_out;
  logic             m_err;

  always #5 clk = ~clk;

  mux_n_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err_clr(err_clr),
    .sel_err(sel_err)
  );

  function automatic logic [WIDTH-1:0] ref_word(logic [NUM_IN*WIDTH-1:0] d, int s);
    if (s >= NUM_IN) return '0;
    return d[s*WIDTH +: WIDTH];
  endfunction

  // Drive inputs for one cycle, advance the model across the rising edge,
  // and return at the following falling edge, where outputs are sampled.
  task automatic drive(input logic v, input int s, input logic [NUM_IN*WIDTH-1:0] d,
                       input logic ordy, input logic clr);
    logic acc, rel;
    in_valid  = v;
    in_sel    = SEL_W'(s);
    in_data   = d;
    out_ready = ordy;
    err_clr   = clr;
    acc = v && (m_q.size() < 2);
    rel = (m_q.size() > 0) && ordy;
    @(posedge clk);
    if (rel) void'(m_q.pop_front());
    if (acc) m_q.push_back(ref_word(d, s));
    if (ERR_EN) begin
      if (acc && s >= NUM_IN) m_err = 1'b1;
      else if (clr)           m_err = 1'b0;
    end
    if (m_q.size() > 0) m_out = m_q[0];
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = 1'b0; err_clr = 1'b0;
    rst_n = 1'b0;
    m_q.delete(); m_out = '0; m_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Power-up reset, sampled before any clock edge.
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0;
    out_ready = 1'b0; err_clr = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: got vld=%b rdy=%b data=%h err=%b, want 0 1 00 0",
               out_valid, in_ready, out_data, sel_err);
    end
    do_reset();
    // Fill to TWO with sel_err set, then reset between clock edges.
    drive(1'b1, 3, 24'h0000AB, 1'b0, 1'b0);
    drive(1'b1, 0, 24'h0000C4, 1'b0, 1'b0);
    n_tests++;
    if (in_ready !== 1'b0 || out_data !== 8'h00 || sel_err !== ERR_EN) begin
      n_fail++;
      $display("FAIL reset_prefill: got rdy=%b data=%h err=%b, want 0 00 %b",
               in_ready, out_data, sel_err, ERR_EN);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midstream: got vld=%b rdy=%b data=%h err=%b, want 0 1 00 0",
               out_valid, in_ready, out_data, sel_err);
    end
    do_reset();
  endtask

  task automatic test_streaming();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i, 24'h332211, 1'b1, 1'b0);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: got vld=%b data=%h rdy=%b, want 1 %h 1",
                 i, out_valid, out_data, in_ready, exp[i]);
      end
    end
    drive(1'b0, 0, '0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h33) begin
      n_fail++;
      $display("FAIL stream_drain: got vld=%b data=%h, want 0 33", out_valid, out_data);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 0, 24'h0000A1, 1'b0, 1'b0);
    drive(1'b1, 2, 24'hA20000, 1'b0, 1'b0);
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA1) begin
      n_fail++;
      $display("FAIL bp_full: got rdy=%b vld=%b data=%h, want 0 1 a1", in_ready, out_valid, out_data);
    end
    // Offered word while full must be ignored, and the output must not move.
    drive(1'b1, 1, 24'h00EE00, 1'b0, 1'b0);
    n_tests++;
    if (in_ready !== 1'b0 || out_data !== 8'hA1) begin
      n_fail++;
      $display("FAIL bp_stall: got rdy=%b data=%h, want 0 a1", in_ready, out_data);
    end
    drive(1'b0, 0, '0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hA2 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: got vld=%b data=%h rdy=%b, want 1 a2 1", out_valid, out_data, in_ready);
    end
    drive(1'b0, 0, '0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'hA2) begin
      n_fail++;
      $display("FAIL bp_empty: got vld=%b data=%h, want 0 a2", out_valid, out_data);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 3, 24'hFFFFFF, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h00 || sel_err !== ERR_EN) begin
      n_fail++;
      $display("FAIL oor_capture: got vld=%b data=%h err=%b, want 1 00 %b",
               out_valid, out_data, sel_err, ERR_EN);
    end
    drive(1'b1, 1, 24'h007700, 1'b1, 1'b0);
    n_tests++;
    if (out_data !== 8'h77 || sel_err !== ERR_EN) begin
      n_fail++;
      $display("FAIL oor_hold: got data=%h err=%b, want 77 %b", out_data, sel_err, ERR_EN);
    end
    drive(1'b0, 0, '0, 1'b1, 1'b1);
    n_tests++;
    if (sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_clear: got err=%b, want 0", sel_err);
    end
  endtask

  task automatic test_set_vs_clear();
    drive(1'b1, 3, 24'h123456, 1'b1, 1'b1);
    n_tests++;
    if (sel_err !== ERR_EN || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL set_vs_clear: got err=%b data=%h, want %b 00", sel_err, out_data, ERR_EN);
    end
    drive(1'b0, 0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_accept_release_one();
    drive(1'b1, 0, 24'h000011, 1'b0, 1'b0);
    drive(1'b1, 1, 24'h005C00, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h5C || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL acc_rel_one: got vld=%b data=%h rdy=%b, want 1 5c 1", out_valid, out_data, in_ready);
    end
    drive(1'b0, 0, '0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL acc_rel_drain: got vld=%b, want 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 24'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
      n_tests++;
      if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2) ||
          out_data !== m_out || sel_err !== m_err) begin
        n_fail++;
        $display("FAIL random_%0d: got vld=%b rdy=%b data=%h err=%b, want %b %b %h %b",
                 i, out_valid, in_ready, out_data, sel_err,
                 (m_q.size() > 0), (m_q.size() < 2), m_out, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_out_of_range();
    test_set_vs_clear();
    test_accept_release_one();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_reg.md
MUX_N_REG -- requirements
Module: mux_n_reg

Interface
- REQ-001 Parameter WIDTH, default 8: data width of each input and of the output, in bits; legal values are 1 or more.
- REQ-002 Parameter NUM_IN, default 4: number of selectable inputs; legal values are 2 or more.
- REQ-003 Derived constant SEL_W SHALL equal max(1, ceil(log2(NUM_IN))) and SHALL NOT be overridable.
- REQ-004 One clock and an asynchronous, active-low reset:
  - clk  input  1  rising-edge clock.
  - rst_n  input  1  asynchronous, active-low reset.
- REQ-005 Input side:
  - in_data  input  NUM_IN*WIDTH  packed inputs; input i is bits [i*WIDTH +: WIDTH].
  - in_sel  input  SEL_W  index of the selected input.
  - in_valid  input  1  upstream offers in_data/in_sel.
  - in_ready  output  1  block can accept this cycle.
- REQ-006 Output side:
  - out_data  output  WIDTH  selected, registered word.
  - out_valid  output  1  out_data holds a valid word.
  - out_ready  input  1  downstream consumes out_data.
- REQ-007 Error side:
  - err_clr  input  1  clears sel_err.
  - sel_err  output  1  sticky out-of-range-select flag.

Function
- REQ-008 An accept SHALL occur on a rising clk edge where in_valid=1 and in_ready=1; a release SHALL occur on a rising clk edge where out_valid=1 and out_ready=1.
- REQ-009 On an accept, the block SHALL capture in_data slice in_sel; when in_sel >= NUM_IN, it SHALL capture all-zeros.
- REQ-010 Storage SHALL be an output register plus one skid register, tracked by a state machine with states EMPTY, ONE and TWO.
- REQ-011 Outputs SHALL be derived from the state register only, with no combinational path from in_valid or out_ready:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
- REQ-012 State transitions:
  - EMPTY, accept -> ONE.
  - ONE, accept and no release -> TWO (word goes to skid).
  - ONE, accept and release -> ONE (output register loads the new word).
  - ONE, release and no accept -> EMPTY.
  - TWO, release -> ONE (skid word moves to the output register).
  - All other cases: hold.
- REQ-013 Latency SHALL be exactly 1 cycle: a word accepted at edge k is presented on out_data with out_valid=1 immediately after edge k whenever state was EMPTY, or was ONE with a same-edge release.
- REQ-014 Sustained throughput SHALL be one word per cycle while out_ready=1.
- REQ-015 out_data SHALL remain stable while out_valid=1 and out_ready=0.
- REQ-016 Words SHALL leave in accept order, with no loss or duplication.
- REQ-017 out_data SHALL hold its last value while state=EMPTY.
- REQ-018 in_sel and in_data SHALL be ignored on cycles without an accept.

Reset
- REQ-019 While rst_n=0, the block SHALL set state=EMPTY, out_data=0, skid register=0 and sel_err=0, independent of clk.
- REQ-020 Consequently, during and after reset: out_valid=0, in_ready=1 and sel_err=0.
- REQ-021 Reset asserted mid-operation SHALL discard both stored words.
- REQ-022 The first accept after reset SHALL be possible on the first rising edge with rst_n=1.

Configuration
- REQ-023 Macro MUX_N_REG_SELERR_EN defined:
  - sel_err SHALL be set on any accept with in_sel >= NUM_IN.
  - sel_err SHALL be cleared on an edge with err_clr=1.
  - If set and clear occur on the same edge, set SHALL win.
  - Otherwise sel_err SHALL hold.
- REQ-024 Macro MUX_N_REG_SELERR_EN undefined:
  - sel_err SHALL be constant 0 and err_clr SHALL be ignored.
  - Data behaviour, including zero substitution for an out-of-range select, SHALL be unchanged.

Verification
- REQ-025 The bench SHALL use WIDTH=8 and NUM_IN=3, and SHALL run all scenarios with the macro defined and with it undefined.
- REQ-026 Directed scenarios the bench SHALL cover:
  - Reset: rst_n low mid-stream with state=TWO -> out_valid=0, in_ready=1, out_data=0x00 and sel_err=0, with no clock edge required.
  - Streaming: inputs {0x11,0x22,0x33}; sel 0,1,2 on consecutive cycles; out_ready=1 -> out_data 0x11, 0x22, 0x33 on consecutive cycles, with in_ready=1 throughout.
  - Backpressure: out_ready=0 while sending 0xA1 then 0xA2 -> in_ready=0 after the second accept and out_data stays 0xA1; then out_ready=1 -> 0xA1, then 0xA2, then EMPTY.
  - Out of range: sel=3 with data 0xFF -> out_data=0x00. Macro defined: sel_err=1 and holds until err_clr. Macro undefined: sel_err stays 0.
  - Set-versus-clear: err_clr=1 on the same edge as a sel=3 accept -> sel_err=1.
  - Simultaneous accept and release in ONE: word 0x5C accepted while 0x11 is released -> state stays ONE and out_data=0x5C on the next cycle.
